tlb: RTL and testbench

Sixteen-entry fully-associative LoongArch TLB holding the translation state that the write-back stage's TLB instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) initiate.
- It serves two combinational lookup ports: s0 for instruction fetch and s1 for load/store and TLBSRCH.
- It serves one combinational read port for TLBRD.
- It takes one synchronous write port for TLBWR/TLBFILL and one synchronous INVTLB invalidation port.

---
 rtl/tlb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tlb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb.sv
// tlb: sixteen-entry fully-associative LoongArch TLB built from flops.
// Two combinational search ports (s0 fetch, s1 load/store + TLBSRCH), one
// combinational read port (TLBRD), one synchronous write port (TLBWR/TLBFILL)
// and one synchronous INVTLB port that takes its operands from s1.
module tlb #(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,

    // search port 0: instruction fetch
    input  logic [18:0]      s0_vppn,
    input  logic             s0_va_bit12,
    input  logic [9:0]       s0_asid,
    output logic             s0_found,
    output logic [IDX_W-1:0] s0_index,
    output logic [19:0]      s0_ppn,
    output logic [5:0]       s0_ps,
    output logic [1:0]       s0_plv,
    output logic [1:0]       s0_mat,
    output logic             s0_d,
    output logic             s0_v,

    // search port 1: load/store, TLBSRCH, INVTLB operands
    input  logic [18:0]      s1_vppn,
    input  logic             s1_va_bit12,
    input  logic [9:0]       s1_asid,
    output logic             s1_found,
    output logic [IDX_W-1:0] s1_index,
    output logic [19:0]      s1_ppn,
    output logic [5:0]       s1_ps,
    output logic [1:0]       s1_plv,
    output logic [1:0]       s1_mat,
    output logic             s1_d,
    output logic             s1_v,

    // INVTLB
    input  logic             invtlb_valid,
    input  logic [4:0]       invtlb_op,

    // write port
    input  logic             we,
    input  logic [IDX_W-1:0] w_index,
    input  logic             w_e,
    input  logic [5:0]       w_ps,
    input  logic [18:0]      w_vppn,
    input  logic [9:0]       w_asid,
    input  logic             w_g,
    input  logic [19:0]      w_ppn0,
    input  logic [1:0]       w_plv0,
    input  logic [1:0]       w_mat0,
    input  logic             w_d0,
    input  logic             w_v0,
    input  logic [19:0]      w_ppn1,
    input  logic [1:0]       w_plv1,
    input  logic [1:0]       w_mat1,
    input  logic             w_d1,
    input  logic             w_v1,

    // read port
    input  logic [IDX_W-1:0] r_index,
    output logic             r_e,
    output logic [18:0]      r_vppn,
    output logic [5:0]       r_ps,
    output logic [9:0]       r_asid,
    output logic             r_g,
    output logic [19:0]      r_ppn0,
    output logic [1:0]       r_plv0,
    output logic [1:0]       r_mat0,
    output logic             r_d0,
    output logic             r_v0,
    output logic [19:0]      r_ppn1,
    output logic [1:0]       r_plv1,
    output logic [1:0]       r_mat1,
    output logic             r_d1,
    output logic             r_v1
);

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } page_t;

    typedef struct packed {
        logic        e;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        page_t       p0;
        page_t       p1;
    } entry_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
        logic [5:0]       ps;
        page_t            pg;
    } hit_t;

    // 4 MB pages compare only VA[31:22]; every other ps value is a 4 KB compare.
    localparam logic [5:0] PS_4M = 6'd21;

    localparam logic [4:0] OP_ALL0      = 5'd0;
    localparam logic [4:0] OP_ALL1      = 5'd1;
    localparam logic [4:0] OP_GLOBAL    = 5'd2;
    localparam logic [4:0] OP_NONGLOBAL = 5'd3;
    localparam logic [4:0] OP_ASID      = 5'd4;
    localparam logic [4:0] OP_ASID_VA   = 5'd5;
    localparam logic [4:0] OP_GASID_VA  = 5'd6;

    entry_t tlb_q [TLBNUM];
    entry_t tlb_d [TLBNUM];

    entry_t            w_entry;
    entry_t            r_entry;
    hit_t              s0_hit;
    hit_t              s1_hit;
    logic [TLBNUM-1:0] inv_sel;

    // Page-number compare honouring the entry's own page size.
    function automatic logic vppn_hit(input entry_t ent, input logic [18:0] vppn);
        if (ent.ps == PS_4M) begin
            return ent.vppn[18:9] == vppn[18:9];
        end
        return ent.vppn == vppn;
    endfunction

    // Full associative search; lowest matching index wins, page chosen by the odd bit.
    function automatic hit_t lookup(input entry_t ents [TLBNUM], input logic [18:0] vppn,
                                    input logic va_bit12, input logic [9:0] asid);
        hit_t   res;
        entry_t hit_ent;
        logic   odd;
        res     = '0;
        hit_ent = '0;
        odd     = 1'b0;
        // Walk from the top down so the lowest matching index is the one left standing.
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (ents[i].e && (ents[i].g || ents[i].asid == asid) && vppn_hit(ents[i], vppn)) begin
                res.found = 1'b1;
                res.index = IDX_W'(i);
                hit_ent   = ents[i];
            end
        end
        if (res.found) begin
            odd    = (hit_ent.ps == PS_4M) ? vppn[8] : va_bit12;
            res.ps = hit_ent.ps;
            res.pg = odd ? hit_ent.p1 : hit_ent.p0;
        end
        return res;
    endfunction

    assign w_entry = '{
        e:    w_e,
        ps:   w_ps,
        vppn: w_vppn,
        asid: w_asid,
        g:    w_g,
        p0:   '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
        p1:   '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}
    };

    // Both search ports look at current state only; writes land next cycle.
    always_comb begin
        s0_hit = lookup(tlb_q, s0_vppn, s0_va_bit12, s0_asid);
        s1_hit = lookup(tlb_q, s1_vppn, s1_va_bit12, s1_asid);
    end

    assign s0_found = s0_hit.found;
    assign s0_index = s0_hit.index;
    assign s0_ps    = s0_hit.ps;
    assign s0_ppn   = s0_hit.pg.ppn;
    assign s0_plv   = s0_hit.pg.plv;
    assign s0_mat   = s0_hit.pg.mat;
    assign s0_d     = s0_hit.pg.d;
    assign s0_v     = s0_hit.pg.v;

    assign s1_found = s1_hit.found;
    assign s1_index = s1_hit.index;
    assign s1_ps    = s1_hit.ps;
    assign s1_ppn   = s1_hit.pg.ppn;
    assign s1_plv   = s1_hit.pg.plv;
    assign s1_mat   = s1_hit.pg.mat;
    assign s1_d     = s1_hit.pg.d;
    assign s1_v     = s1_hit.pg.v;

    // Select the entries an INVTLB of the given op would clear (A/V from port s1).
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        inv_sel = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (invtlb_op)
                OP_ALL0, OP_ALL1: inv_sel[i] = 1'b1;
                OP_GLOBAL:        inv_sel[i] = tlb_q[i].g;
                OP_NONGLOBAL:     inv_sel[i] = !tlb_q[i].g;
                OP_ASID:          inv_sel[i] = !tlb_q[i].g && (tlb_q[i].asid == s1_asid);
                OP_ASID_VA:       inv_sel[i] = !tlb_q[i].g && (tlb_q[i].asid == s1_asid)
                                               && vppn_hit(tlb_q[i], s1_vppn);
                OP_GASID_VA:      inv_sel[i] = (tlb_q[i].g || tlb_q[i].asid == s1_asid)
                                               && vppn_hit(tlb_q[i], s1_vppn);
                default:          inv_sel[i] = 1'b0;
            endcase
        end
    end

    // Next-state: invalidation first, then the write overrides its own index.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see the
        // earlier ones (the write must overwrite the invalidation result here).
        for (int i = 0; i < TLBNUM; i++) begin
            tlb_d[i] = tlb_q[i];
            if (invtlb_valid && inv_sel[i]) begin
                tlb_d[i].e = 1'b0;
            end
        end
        if (we) begin
            tlb_d[w_index] = w_entry;
        end
    end

    // Entry storage; synchronous reset wins over any write or invalidation.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking '<=' so every flop samples
        // pre-edge values; the array is flops rather than RAM, so it is reset.
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_q[i] <= tlb_d[i];
            end
        end
    end

    // TLBRD: raw entry contents, valid or not.
    assign r_entry = tlb_q[r_index];
    assign r_e     = r_entry.e;
    assign r_vppn  = r_entry.vppn;
    assign r_ps    = r_entry.ps;
    assign r_asid  = r_entry.asid;
    assign r_g     = r_entry.g;
    assign r_ppn0  = r_entry.p0.ppn;
    assign r_plv0  = r_entry.p0.plv;
    assign r_mat0  = r_entry.p0.mat;
    assign r_d0    = r_entry.p0.d;
    assign r_v0    = r_entry.p0.v;
    assign r_ppn1  = r_entry.p1.ppn;
    assign r_plv1  = r_entry.p1.plv;
    assign r_mat1  = r_entry.p1.mat;
    assign r_d1    = r_entry.p1.d;
    assign r_v1    = r_entry.p1.v;

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed self-checking bench for the tlb block.
module tb_tlb;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] s0_vppn, s1_vppn;
    logic        s0_va_bit12, s1_va_bit12;
    logic [9:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_ppn, s1_ppn;
    logic [5:0]  s0_ps, s1_ps;
    logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic        we;
    logic [3:0]  w_index;
    logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [5:0]  w_ps;
    logic [18:0] w_vppn;
    logic [9:0]  w_asid;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
    logic [3:0]  r_index;
    logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;

    tlb dut (
        .clk(clk), .reset(reset),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
        .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
        .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
        .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
        .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        e;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0, ppn1;
        logic [1:0]  plv0, mat0, plv1, mat1;
        logic        d0, v0, d1, v1;
    } tb_ent_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic tb_ent_t mk(input logic e, input logic [5:0] ps, input logic [18:0] vppn,
                                   input logic [9:0] asid, input logic g,
                                   input logic [19:0] ppn0, input logic [19:0] ppn1);
        tb_ent_t t;
        t.e = e; t.ps = ps; t.vppn = vppn; t.asid = asid; t.g = g;
        t.ppn0 = ppn0; t.plv0 = 2'd0; t.mat0 = 2'd1; t.d0 = 1'b0; t.v0 = 1'b1;
        t.ppn1 = ppn1; t.plv1 = 2'd0; t.mat1 = 2'd1; t.d1 = 1'b0; t.v1 = 1'b1;
        return t;
    endfunction

    task automatic set_w(input logic [3:0] idx, input tb_ent_t t);
        w_index = idx; w_e = t.e; w_ps = t.ps; w_vppn = t.vppn; w_asid = t.asid; w_g = t.g;
        w_ppn0 = t.ppn0; w_plv0 = t.plv0; w_mat0 = t.mat0; w_d0 = t.d0; w_v0 = t.v0;
        w_ppn1 = t.ppn1; w_plv1 = t.plv1; w_mat1 = t.mat1; w_d1 = t.d1; w_v1 = t.v1;
    endtask

    task automatic do_write(input logic [3:0] idx, input tb_ent_t t);
        set_w(idx, t);
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic do_inv(input logic [4:0] op, input logic [9:0] a, input logic [18:0] v);
        invtlb_op = op; s1_asid = a; s1_vppn = v; invtlb_valid = 1'b1;
        @(posedge clk);
        #1;
        invtlb_valid = 1'b0;
    endtask

    task automatic check_e(input string tag, input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            check($sformatf("%s r_e[%0d]", tag, i), 32'(r_e), 32'(mask[i]));
        end
    endtask

    task automatic fill_0_3();
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i), mk(1'b1, 6'd12, 19'h00100 + 19'(i), 10'd5, 1'(i % 2), 20'h01000, 20'h01001));
        end
    endtask

    tb_ent_t ent;

    initial begin
        reset = 1'b1; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = 5'd0;
        s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
        s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
        r_index = '0;
        set_w(4'd0, mk(1'b0, 6'd0, 19'h0, 10'h0, 1'b0, 20'h0, 20'h0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        r_index = 4'd5; #1;
        check("rst s0_found", 32'(s0_found), 0);
        check("rst s1_found", 32'(s1_found), 0);
        check("rst s0_index", 32'(s0_index), 0);
        check("rst s0_ppn",   32'(s0_ppn), 0);
        check("rst r_e",      32'(r_e), 0);
        check("rst r_vppn",   32'(r_vppn), 0);

        // Entry 3, 4 KB page, non-global asid 5; read in the write cycle sees old contents
        ent = mk(1'b1, 6'd12, 19'h12345, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
        ent.plv0 = 2'd1; ent.mat0 = 2'd2; ent.d0 = 1'b1;
        ent.plv1 = 2'd3; ent.mat1 = 2'd1; ent.d1 = 1'b0;
        set_w(4'd3, ent); we = 1'b1; r_index = 4'd3; #1;
        check("wr3 same-cycle r_e", 32'(r_e), 0);
        @(posedge clk); #1; we = 1'b0;

        s0_vppn = 19'h12345; s0_asid = 10'd5; s0_va_bit12 = 1'b1; #1;
        check("e3 odd found", 32'(s0_found), 1);
        check("e3 odd index", 32'(s0_index), 3);
        check("e3 odd ppn",   32'(s0_ppn), 32'hBBBBB);
        check("e3 odd ps",    32'(s0_ps), 12);
        check("e3 odd plv",   32'(s0_plv), 3);
        check("e3 odd mat",   32'(s0_mat), 1);
        check("e3 odd d",     32'(s0_d), 0);
        check("e3 odd v",     32'(s0_v), 1);
        s0_va_bit12 = 1'b0; #1;
        check("e3 even ppn",  32'(s0_ppn), 32'hAAAAA);
        check("e3 even plv",  32'(s0_plv), 1);
        check("e3 even mat",  32'(s0_mat), 2);
        check("e3 even d",    32'(s0_d), 1);
        s0_asid = 10'd6; #1;
        check("e3 asid miss found", 32'(s0_found), 0);
        check("e3 asid miss index", 32'(s0_index), 0);
        check("e3 asid miss ppn",   32'(s0_ppn), 0);

        r_index = 4'd3; #1;
        check("rd3 e",    32'(r_e), 1);
        check("rd3 ps",   32'(r_ps), 12);
        check("rd3 vppn", 32'(r_vppn), 32'h12345);
        check("rd3 asid", 32'(r_asid), 5);
        check("rd3 g",    32'(r_g), 0);
        check("rd3 ppn0", 32'(r_ppn0), 32'hAAAAA);
        check("rd3 ppn1", 32'(r_ppn1), 32'hBBBBB);
        check("rd3 plv0", 32'(r_plv0), 1);
        check("rd3 plv1", 32'(r_plv1), 3);
        check("rd3 mat0", 32'(r_mat0), 2);
        check("rd3 mat1", 32'(r_mat1), 1);
        check("rd3 d0",   32'(r_d0), 1);
        check("rd3 d1",   32'(r_d1), 0);
        check("rd3 v0",   32'(r_v0), 1);
        check("rd3 v1",   32'(r_v1), 1);

        // Entry 7, 4 MB global page: odd page chosen by VA[21], VA[12] ignored
        ent = mk(1'b1, 6'd21, 19'h04A00, 10'h3FF, 1'b1, 20'h11111, 20'h22222);
        ent.v0 = 1'b0;
        do_write(4'd7, ent);
        s1_vppn = 19'h04BFF; s1_asid = 10'd9; s1_va_bit12 = 1'b0; #1;
        check("e7 odd found", 32'(s1_found), 1);
        check("e7 odd index", 32'(s1_index), 7);
        check("e7 odd ppn",   32'(s1_ppn), 32'h22222);
        check("e7 odd ps",    32'(s1_ps), 21);
        check("e7 odd v",     32'(s1_v), 1);
        s1_vppn = 19'h04A55; s1_va_bit12 = 1'b1; #1;
        check("e7 even index", 32'(s1_index), 7);
        check("e7 even ppn",   32'(s1_ppn), 32'h11111);
        check("e7 even v",     32'(s1_v), 0);

        // Entries 9 (global) and 2 (asid 1) match the same VA: lowest index wins
        do_write(4'd9, mk(1'b1, 6'd12, 19'h00777, 10'h3FF, 1'b1, 20'h90000, 20'h90001));
        do_write(4'd2, mk(1'b1, 6'd12, 19'h00777, 10'd1, 1'b0, 20'h20000, 20'h20001));
        s0_vppn = 19'h00777; s0_asid = 10'd1; s0_va_bit12 = 1'b0;
        s1_vppn = 19'h00777; s1_asid = 10'd1; s1_va_bit12 = 1'b1; #1;
        check("multi s0 found", 32'(s0_found), 1);
        check("multi s0 index", 32'(s0_index), 2);
        check("multi s0 ppn",   32'(s0_ppn), 32'h20000);
        check("multi s1 index", 32'(s1_index), 2);
        check("multi s1 ppn",   32'(s1_ppn), 32'h20001);
        s0_asid = 10'd2; #1;
        check("multi asid2 index", 32'(s0_index), 9);
        check("multi asid2 ppn",   32'(s0_ppn), 32'h90000);

        // Back-to-back writes to entry 6: last one wins
        do_write(4'd6, mk(1'b1, 6'd12, 19'h00600, 10'd3, 1'b1, 20'h06000, 20'h06001));
        do_write(4'd6, mk(1'b1, 6'd12, 19'h00601, 10'd3, 1'b1, 20'h66666, 20'h06001));
        r_index = 4'd6; #1;
        check("b2b r_vppn", 32'(r_vppn), 32'h601);
        check("b2b r_ppn0", 32'(r_ppn0), 32'h66666);

        // INVTLB ops on entries 0-3 (g alternating 0/1, asid 5, vppn 0x100+i)
        fill_0_3();
        check_e("fill", 16'h02CF);
        do_inv(5'd3, 10'd0, 19'h0);
        check_e("op3", 16'h02CA);
        fill_0_3();
        do_inv(5'd5, 10'd5, 19'h00102);
        check_e("op5", 16'h02CB);
        do_inv(5'd6, 10'd5, 19'h00103);
        check_e("op6", 16'h02C3);
        do_inv(5'd9, 10'd5, 19'h00100);
        check_e("op9", 16'h02C3);
        do_inv(5'd4, 10'd5, 19'h0);
        check_e("op4", 16'h02C2);
        do_inv(5'd2, 10'd0, 19'h0);
        check_e("op2", 16'h0000);

        // INVTLB op 0 with a simultaneous write to entry 4
        do_write(4'd4, mk(1'b1, 6'd12, 19'h00444, 10'd0, 1'b0, 20'h04440, 20'h04441));
        do_write(4'd5, mk(1'b1, 6'd12, 19'h00500, 10'd0, 1'b1, 20'h05000, 20'h05001));
        set_w(4'd4, mk(1'b1, 6'd12, 19'h00555, 10'd0, 1'b0, 20'h05550, 20'h05551));
        we = 1'b1; invtlb_op = 5'd0; invtlb_valid = 1'b1; r_index = 4'd4; #1;
        check("inv+wr old r_vppn", 32'(r_vppn), 32'h444);
        check("inv+wr old r_e",    32'(r_e), 1);
        @(posedge clk); #1;
        we = 1'b0; invtlb_valid = 1'b0;
        check_e("inv+wr", 16'h0010);
        r_index = 4'd4; #1;
        check("inv+wr new r_vppn", 32'(r_vppn), 32'h555);

        // Populate all 16 entries, then reset in the same cycle as a write
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), mk(1'b1, 6'd12, 19'h00200 + 19'(i), 10'd0, 1'b1, 20'h30000 + 20'(i), 20'h0));
        end
        s0_vppn = 19'h00205; s0_asid = 10'd0; s0_va_bit12 = 1'b0;
        s1_vppn = 19'h0020A; s1_asid = 10'd0; s1_va_bit12 = 1'b0; #1;
        check("full s0 index", 32'(s0_index), 5);
        check("full s1 ppn",   32'(s1_ppn), 32'h3000A);
        set_w(4'd5, mk(1'b1, 6'd12, 19'h00205, 10'd0, 1'b1, 20'h77777, 20'h0));
        we = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; reset = 1'b0;
        check_e("rst+wr", 16'h0000);
        r_index = 4'd5; #1;
        check("rst+wr s0_found", 32'(s0_found), 0);
        check("rst+wr s1_found", 32'(s1_found), 0);
        check("rst+wr s0_ppn",   32'(s0_ppn), 0);
        check("rst+wr r_vppn",   32'(r_vppn), 0);
        check("rst+wr r_ppn0",   32'(r_ppn0), 0);
        check("rst+wr r_ps",     32'(r_ps), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
